// File: rtl/mod_74x163_counter.sv
// Synchronous binary counter built from cascaded 74x163-style 4-bit slices (clear, load, ENP/ENT, RCO).
// Define MOD_74X163_COUNTER_MODULO_EN to add a decoded terminal-count clear at MODULUS-1.
module mod_74x163_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             LD,
    input  logic             ENP,
    input  logic             ENT,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             RCO
);
    localparam int SLICES = WIDTH / 4;
`ifdef MOD_74X163_COUNTER_MODULO_EN
    localparam bit MODULO_EN = 1'b1;
    localparam logic [WIDTH-1:0] TC = WIDTH'(MODULUS - 1);
`else
    localparam bit MODULO_EN = 1'b0;
`endif

    if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_bad_width
        $error("mod_74x163_counter: WIDTH must be a positive multiple of 4");
    end
    if (MODULO_EN && (MODULUS < 2 || MODULUS > (1 << WIDTH))) begin : g_bad_modulus
        $error("mod_74x163_counter: MODULUS must be in 2..2**WIDTH");
    end

    logic [WIDTH-1:0]  q_q;
    logic [WIDTH-1:0]  q_d;
    logic [SLICES-1:0] slice_rco;
    logic              ent_k;
    logic [3:0]        nib;
    logic              rco_int;

    // Each slice counts when ENP and its chained ENT are high; its RCO feeds the next slice's ENT.
    always_comb begin
        q_d       = q_q;
        slice_rco = '0;
        ent_k     = ENT;
        nib       = '0;
        for (int k = 0; k < SLICES; k++) begin
            nib          = q_q[4*k +: 4];
            slice_rco[k] = ent_k & (nib == 4'hF);
            if (ENP && ent_k) begin
                q_d[4*k +: 4] = nib + 4'd1;
            end
            ent_k = slice_rco[k];
        end
`ifdef MOD_74X163_COUNTER_MODULO_EN
        // Decoded terminal count: out-of-range values above TC still wrap through all-ones.
        rco_int = ENT & (q_q == TC);
        if (ENP && rco_int) begin
            q_d = '0;
        end
`else
        rco_int = slice_rco[SLICES-1];
`endif
        if (LD) begin
            q_d = D;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign Q   = q_q;
    assign RCO = rco_int;

endmodule
